// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for the LCD byte writer: FSM states, HD44780 init
// nibbles, configuration command bytes and the slow-command codes.
package lcd_byte_writer_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned PCNT_W = 16;
  localparam int unsigned N_INIT = 4;
  localparam int unsigned N_CFG  = 4;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [PCNT_W-1:0] pcnt_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_NIB,
    S_CFG,
    S_IDLE,
    S_SEND_HI,
    S_GAP,
    S_SEND_LO,
    S_POST_WAIT
  } lcd_state_t;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_SETUP,
    PS_HIGH,
    PS_HOLD
  } pulse_state_t;

  // Power-on 4-bit init nibbles: 0x3, 0x3, 0x3, 0x2
  function automatic logic [3:0] f_init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  // Configuration bytes: 4-bit/2-line, entry mode, display on, clear
  function automatic logic [7:0] f_cfg_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h06;
      2'd2:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // Clear and home commands need the long execution wait
  function automatic logic f_long_wait(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_byte_writer_pulse.sv
// One LCD nibble strobe: data/RS latched on start, E low for setup,
// high for the strobe width, low for hold, then a one-cycle done.
module lcd_nibble_pulse
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned P_E_SETUP = 2,
  parameter int unsigned P_E_HIGH  = 12,
  parameter int unsigned P_E_HOLD  = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [3:0] iNibble,
  input  logic       iRS,
  output logic       oDone,
  output logic       oE,
  output logic [3:0] oData,
  output logic       oRS
);

  pulse_state_t r_state;
  pulse_state_t w_next;
  pcnt_t        r_cnt;
  pcnt_t        w_load_val;
  logic         w_load;
  logic         w_cnt_done;
  logic [3:0]   r_data;
  logic         r_rs;

  // A loaded count N gives N cycles; 0 behaves as 1
  assign w_cnt_done = (r_cnt <= pcnt_t'(1));

  // Phase register, phase-length counter and held nibble/RS
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= PS_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_rs    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cnt <= w_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - pcnt_t'(1);
      end
      if ((r_state == PS_IDLE) && iStart) begin
        r_data <= iNibble;
        r_rs   <= iRS;
      end
    end
  end

  // Phase sequencing setup -> high -> hold
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    oDone      = 1'b0;
    case (r_state)
      PS_IDLE: begin
        if (iStart) begin
          w_next     = PS_SETUP;
          w_load     = 1'b1;
          w_load_val = pcnt_t'(P_E_SETUP);
        end
      end
      PS_SETUP: begin
        if (w_cnt_done) begin
          w_next     = PS_HIGH;
          w_load     = 1'b1;
          w_load_val = pcnt_t'(P_E_HIGH);
        end
      end
      PS_HIGH: begin
        if (w_cnt_done) begin
          w_next     = PS_HOLD;
          w_load     = 1'b1;
          w_load_val = pcnt_t'(P_E_HOLD);
        end
      end
      PS_HOLD: begin
        if (w_cnt_done) begin
          w_next = PS_IDLE;
          oDone  = 1'b1;
        end
      end
      default: w_next = PS_IDLE;
    endcase
  end

  assign oE    = (r_state == PS_HIGH);
  assign oData = r_data;
  assign oRS   = r_rs;

endmodule

// File: rtl/lcd_byte_writer.sv
// CPU-to-LCD byte writer: HD44780 4-bit power-on init, configuration,
// then accepts bytes on a ready/write handshake and sends two nibbles each.
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned P_POWERON_WAIT = 750000,
  parameter int unsigned P_WAIT_4MS     = 205000,
  parameter int unsigned P_WAIT_100US   = 5000,
  parameter int unsigned P_WAIT_40US    = 2000,
  parameter int unsigned P_WAIT_1640US  = 82000,
  parameter int unsigned P_E_SETUP      = 2,
  parameter int unsigned P_E_HIGH       = 12,
  parameter int unsigned P_E_HOLD       = 1,
  parameter int unsigned P_NIBBLE_GAP   = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic [7:0] iData,
  input  logic       iRegisterSelect,
  output logic       oReady,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_StrataFlashControl,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  lcd_state_t r_state;
  lcd_state_t w_next;
  cnt_t       r_cnt;
  cnt_t       w_load_val;
  logic       w_load;
  logic       w_cnt_done;
  logic [2:0] r_init_idx;
  logic [2:0] w_init_idx_next;
  logic [1:0] r_cfg_idx;
  logic [1:0] w_cfg_idx_next;
  logic       r_cfg_mode;
  logic       w_cfg_mode_next;
  logic [7:0] r_byte;
  logic       r_rs;
  logic       w_latch;
  logic [7:0] w_latch_byte;
  logic       w_latch_rs;
  logic       w_start;
  logic [3:0] w_nib;
  logic       w_nib_rs;
  logic       w_pulse_done;

  assign w_cnt_done = (r_cnt <= cnt_t'(1));

  // State, shared wait counter, sequencing indices and latched byte
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_INIT_WAIT;
      r_cnt      <= cnt_t'(P_POWERON_WAIT);
      r_init_idx <= '0;
      r_cfg_idx  <= '0;
      r_cfg_mode <= 1'b1;
      r_byte     <= '0;
      r_rs       <= 1'b0;
    end else begin
      r_state    <= w_next;
      if (w_load) begin
        r_cnt <= w_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - cnt_t'(1);
      end
      r_init_idx <= w_init_idx_next;
      r_cfg_idx  <= w_cfg_idx_next;
      r_cfg_mode <= w_cfg_mode_next;
      if (w_latch) begin
        r_byte <= w_latch_byte;
        r_rs   <= w_latch_rs;
      end
    end
  end

  // Next state; nibble starts are issued on the entering transition so the
  // pulse occupies exactly the cycles of SEND_HI/SEND_LO/INIT_NIB.
  // INIT_WAIT doubles as the wait after each init nibble, tracked by r_init_idx.
  always_comb begin
    w_next          = r_state;
    w_load          = 1'b0;
    w_load_val      = '0;
    w_init_idx_next = r_init_idx;
    w_cfg_idx_next  = r_cfg_idx;
    w_cfg_mode_next = r_cfg_mode;
    w_latch         = 1'b0;
    w_latch_byte    = '0;
    w_latch_rs      = 1'b0;
    w_start         = 1'b0;
    w_nib           = '0;
    w_nib_rs        = 1'b0;
    case (r_state)
      S_INIT_WAIT: begin
        if (w_cnt_done) begin
          if (r_init_idx == 3'(N_INIT)) begin
            w_next = S_CFG;
          end else begin
            w_start = 1'b1;
            w_nib   = f_init_nibble(r_init_idx[1:0]);
            w_next  = S_INIT_NIB;
          end
        end
      end
      S_INIT_NIB: begin
        if (w_pulse_done) begin
          w_load = 1'b1;
          case (r_init_idx[1:0])
            2'd0:    w_load_val = cnt_t'(P_WAIT_4MS);
            2'd1:    w_load_val = cnt_t'(P_WAIT_100US);
            default: w_load_val = cnt_t'(P_WAIT_40US);
          endcase
          w_init_idx_next = r_init_idx + 3'd1;
          w_next          = S_INIT_WAIT;
        end
      end
      S_CFG: begin
        w_latch      = 1'b1;
        w_latch_byte = f_cfg_byte(r_cfg_idx);
        w_latch_rs   = 1'b0;
        w_start      = 1'b1;
        w_nib        = w_latch_byte[7:4];
        w_nib_rs     = 1'b0;
        w_next       = S_SEND_HI;
      end
      S_IDLE: begin
        if (iWrite) begin
          w_latch      = 1'b1;
          w_latch_byte = iData;
          w_latch_rs   = iRegisterSelect;
          w_start      = 1'b1;
          w_nib        = iData[7:4];
          w_nib_rs     = iRegisterSelect;
          w_next       = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (w_pulse_done) begin
          w_load     = 1'b1;
          w_load_val = cnt_t'(P_NIBBLE_GAP);
          w_next     = S_GAP;
        end
      end
      S_GAP: begin
        if (w_cnt_done) begin
          w_start  = 1'b1;
          w_nib    = r_byte[3:0];
          w_nib_rs = r_rs;
          w_next   = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (w_pulse_done) begin
          w_load     = 1'b1;
          w_load_val = f_long_wait(r_rs, r_byte) ? cnt_t'(P_WAIT_1640US)
                                                 : cnt_t'(P_WAIT_40US);
          w_next     = S_POST_WAIT;
        end
      end
      S_POST_WAIT: begin
        if (w_cnt_done) begin
          if (r_cfg_mode) begin
            if (r_cfg_idx == 2'(N_CFG - 1)) begin
              w_cfg_mode_next = 1'b0;
              w_next          = S_IDLE;
            end else begin
              w_cfg_idx_next = r_cfg_idx + 2'd1;
              w_next         = S_CFG;
            end
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_INIT_WAIT;
    endcase
  end

  lcd_nibble_pulse #(
    .P_E_SETUP (P_E_SETUP),
    .P_E_HIGH  (P_E_HIGH),
    .P_E_HOLD  (P_E_HOLD)
  ) u_pulse (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (w_start),
    .iNibble (w_nib),
    .iRS     (w_nib_rs),
    .oDone   (w_pulse_done),
    .oE      (oLCD_Enabled),
    .oData   (oLCD_Data),
    .oRS     (oLCD_RegisterSelect)
  );

  assign oReady                  = (r_state == S_IDLE);
  assign oLCD_StrataFlashControl = 1'b1;
  assign oLCD_ReadWrite          = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer with short simulation timings.
module tb_lcd_byte_writer;

  localparam int unsigned T_PON   = 20;
  localparam int unsigned T_4MS   = 10;
  localparam int unsigned T_100US = 6;
  localparam int unsigned T_40US  = 4;
  localparam int unsigned T_1640  = 15;
  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_HIGH  = 3;
  localparam int unsigned T_HOLD  = 1;
  localparam int unsigned T_GAP   = 5;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       iWrite = 1'b0;
  logic [7:0] iData = '0;
  logic       iRegisterSelect = 1'b0;
  logic       oReady;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_StrataFlashControl;
  logic       oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [4:0] cap_q[$];
  logic [4:0] prev_v = '0;
  logic [4:0] pulse_v = '0;
  logic [4:0] cur_v;
  int         stable = 0;
  int         width = 0;
  int         hold_left = 0;
  int         last_fall = 0;
  bit         in_high = 1'b0;
  bit         rst_prev = 1'b0;
  bit         mon_en = 1'b0;

  lcd_byte_writer #(
    .P_POWERON_WAIT (T_PON),
    .P_WAIT_4MS     (T_4MS),
    .P_WAIT_100US   (T_100US),
    .P_WAIT_40US    (T_40US),
    .P_WAIT_1640US  (T_1640),
    .P_E_SETUP      (T_SETUP),
    .P_E_HIGH       (T_HIGH),
    .P_E_HOLD       (T_HOLD),
    .P_NIBBLE_GAP   (T_GAP)
  ) dut (
    .Clock                   (clk),
    .Reset                   (Reset),
    .iWrite                  (iWrite),
    .iData                   (iData),
    .iRegisterSelect         (iRegisterSelect),
    .oReady                  (oReady),
    .oLCD_Enabled            (oLCD_Enabled),
    .oLCD_RegisterSelect     (oLCD_RegisterSelect),
    .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
    .oLCD_ReadWrite          (oLCD_ReadWrite),
    .oLCD_Data               (oLCD_Data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Cycles oReady is low after an accepted byte
  function automatic int exp_busy(input logic [7:0] b, input logic rs);
    int post;
    post = (!rs && (b == 8'h01 || b == 8'h02)) ? T_1640 : T_40US;
    return 2 * (T_SETUP + T_HIGH + T_HOLD) + T_GAP + post;
  endfunction

  // LCD pin monitor: captures strobed nibbles and checks strobe timing
  always @(negedge clk) begin
    if (mon_en) begin
      cur_v = {oLCD_RegisterSelect, oLCD_Data};
      if (rst_prev) begin
        in_high   = 1'b0;
        hold_left = 0;
        stable    = 1;
      end else begin
        if (cur_v == prev_v) stable++;
        else stable = 1;
        if (oLCD_Enabled && !in_high) begin
          check("e_setup", 32'(stable > T_SETUP), 32'd1);
          check("rw_const", 32'(oLCD_ReadWrite), 32'd0);
          check("sf_const", 32'(oLCD_StrataFlashControl), 32'd1);
          cap_q.push_back(cur_v);
          pulse_v = cur_v;
          in_high = 1'b1;
          width   = 1;
        end else if (oLCD_Enabled) begin
          width++;
          check("e_high_data", 32'(cur_v), 32'(pulse_v));
        end else if (in_high) begin
          in_high = 1'b0;
          check("e_width", width, T_HIGH);
          hold_left = T_HOLD;
          last_fall = cyc;
        end
        if (!oLCD_Enabled && hold_left > 0) begin
          check("e_hold_data", 32'(cur_v), 32'(pulse_v));
          hold_left--;
        end
      end
      prev_v   = cur_v;
      rst_prev = Reset;
    end
  end

  task automatic check_init();
    int n = 0;
    logic [31:0] got;
    logic [4:0] exp_q[$];
    exp_q = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06,
              5'h00, 5'h0C, 5'h00, 5'h01};
    while (!oReady && n < 3000) begin
      n++;
      tick();
    end
    check("init_ready", 32'(oReady), 32'd1);
    check("ready_after_clear", cyc - last_fall, T_HOLD + T_1640);
    check("init_count", cap_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      got = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF;
      check("init_nib", got, 32'(exp_q[i]));
    end
    cap_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic rs, input bit junk);
    int n;
    logic [31:0] got;
    check("ready_before", 32'(oReady), 32'd1);
    iWrite = 1'b1;
    iData = b;
    iRegisterSelect = rs;
    tick();
    check("ready_drop", 32'(oReady), 32'd0);
    if (!junk) iWrite = 1'b0;
    n = 0;
    while (!oReady && n < 500) begin
      n++;
      if (junk) begin
        iData = 8'($urandom);
        iRegisterSelect = 1'($urandom);
      end
      tick();
    end
    check("busy_cycles", n, exp_busy(b, rs));
    check("nib_count", cap_q.size(), 2);
    got = (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hFFFF_FFFF;
    check("nib_hi", got, 32'({rs, b[7:4]}));
    got = (cap_q.size() > 1) ? 32'(cap_q[1]) : 32'hFFFF_FFFF;
    check("nib_lo", got, 32'({rs, b[3:0]}));
    cap_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    logic rs;
    bit junk;

    Reset = 1'b1;
    tick();
    check("rst_ready", 32'(oReady), 32'd0);
    check("rst_e", 32'(oLCD_Enabled), 32'd0);
    check("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
    check("rst_data", 32'(oLCD_Data), 32'd0);
    check("rst_rw", 32'(oLCD_ReadWrite), 32'd0);
    check("rst_sf", 32'(oLCD_StrataFlashControl), 32'd1);
    mon_en = 1'b1;
    Reset = 1'b0;
    check_init();

    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      rs = 1'($urandom);
      junk = (i == 5) || (i == 6);
      case (i)
        0: begin b = 8'h41; rs = 1'b1; end
        1: begin b = 8'h01; rs = 1'b0; end
        2: begin b = 8'h02; rs = 1'b0; end
        3: begin b = 8'h01; rs = 1'b1; end
        4: begin b = 8'h03; rs = 1'b0; end
        default: ;
      endcase
      if (i != 7) repeat ($urandom_range(0, 3)) tick();
      write_byte(b, rs, junk);
      if (i != 6) iWrite = 1'b0;
    end

    repeat (3) tick();
    check("no_extra_ready", 32'(oReady), 32'd1);
    check("no_extra_nib", cap_q.size(), 0);

    iWrite = 1'b1;
    iData = 8'($urandom);
    iRegisterSelect = 1'b1;
    tick();
    iWrite = 1'b0;
    n = 0;
    while (!oLCD_Enabled && n < 100) begin
      n++;
      tick();
    end
    check("e_seen", 32'(oLCD_Enabled), 32'd1);
    Reset = 1'b1;
    tick();
    check("midrst_e", 32'(oLCD_Enabled), 32'd0);
    check("midrst_ready", 32'(oReady), 32'd0);
    check("midrst_data", 32'(oLCD_Data), 32'd0);
    Reset = 1'b0;
    cap_q.delete();
    check_init();

    write_byte(8'h41, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
